// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order instruction buffer feeding decode, gated by ROB/RS/LSQ space, with flush recovery
module dispatch_ctrl #(
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3,
    parameter int FLUSH_HOLD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_fetch_valid,
    input  logic [31:0]      in_fetch_inst,
    input  logic [31:0]      in_fetch_pc,
    input  logic             in_fetch_pred_taken,
    output logic             out_fetch_ready,
    input  logic             in_rob_full,
    input  logic             in_rs_full,
    input  logic             in_lsq_full,
    input  logic             in_flush,
    output logic             out_dec_ena,
    output logic [31:0]      out_dec_inst,
    output logic [31:0]      out_dec_pc,
    output logic             out_dec_pred_taken,
    output logic [PTR_W:0]   out_count,
    output logic [31:0]      out_stall_cnt
);
    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold, hold_nxt;
    logic [PTR_W-1:0]   head, tail;
    logic [31:0]        mem_inst [DEPTH];
    logic [31:0]        mem_pc   [DEPTH];
    logic               mem_pt   [DEPTH];
    logic [6:0]         opcode;
    logic               is_mem, push, pop;

    assign out_dec_inst       = mem_inst[head];
    assign out_dec_pc         = mem_pc[head];
    assign out_dec_pred_taken = mem_pt[head];
    assign opcode             = mem_inst[head][6:0];
    assign is_mem             = (opcode == 7'b0000011) || (opcode == 7'b0100011);
    assign push               = in_fetch_valid & out_fetch_ready;
    assign pop                = out_dec_ena;

    // Recovery sequencing plus the ready/enable handshakes; a flush suppresses both in the same cycle
    always_comb begin
        state_nxt       = state;
        hold_nxt        = hold;
        out_fetch_ready = rst_n && state == RUN && out_count != (PTR_W+1)'(DEPTH) && !in_flush;
        out_dec_ena     = state == RUN && out_count != '0 && !in_flush && !in_rob_full &&
                          (is_mem ? !in_lsq_full : !in_rs_full);
        if (in_flush) begin
            state_nxt = RECOVER;
            hold_nxt  = HOLD_W'(FLUSH_HOLD - 1);
        end else if (state == RECOVER) begin
            if (hold == '0) state_nxt = RUN;
            else            hold_nxt  = hold - 1'b1;
        end
    end

    // State register for the recovery window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // Circular pointers, occupancy and saturating stall counter; a flush empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            out_count     <= '0;
            out_stall_cnt <= '0;
        end else begin
            if (state == RUN && out_count != '0 && !in_flush && !out_dec_ena && out_stall_cnt != '1)
                out_stall_cnt <= out_stall_cnt + 1'b1;
            if (in_flush) begin
                head      <= '0;
                tail      <= '0;
                out_count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      out_count <= out_count + 1'b1;
                else if (!push && pop) out_count <= out_count - 1'b1;
            end
        end
    end

    // Entry storage is never cleared; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= in_fetch_inst;
            mem_pc[tail]   <= in_fetch_pc;
            mem_pt[tail]   <= in_fetch_pred_taken;
        end
    end
endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Instruction buffer and dispatch sequencer between fetch and the decode stage.
- Holds fetched instructions, each with its PC and predicted-taken bit, in a circular FIFO.
- Drives the decode stage's enable only when the head instruction has a free ROB slot and a free downstream slot: LSQ for load/store, RS for everything else.
- Clears itself and holds off dispatch for a fixed recovery window after a branch-mispredict flush.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH).
- FLUSH_HOLD, 2, cycles spent in RECOVER after a flush; at least 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_fetch_valid  in  1  fetch presents an instruction.
- in_fetch_inst  in  32  instruction word.
- in_fetch_pc  in  32  PC of the instruction.
- in_fetch_pred_taken  in  1  branch predictor result.
- out_fetch_ready  out  1  buffer accepts a push this cycle.
- in_rob_full  in  1  ROB has no free entry.
- in_rs_full  in  1  reservation station has no free entry.
- in_lsq_full  in  1  load/store queue has no free entry.
- in_flush  in  1  mispredict flush, one-cycle pulse.
- out_dec_ena  out  1  decode enable; decode samples it with the head data on the next posedge.
- out_dec_inst  out  32  head instruction.
- out_dec_pc  out  32  head PC.
- out_dec_pred_taken  out  1  head predicted-taken bit.
- out_count  out  PTR_W+1  occupied entries.
- out_stall_cnt  out  32  cycles the head was valid but blocked.

Behaviour:
- Reset (async, rst_n low):
  - head = tail = count = 0; state = RUN; hold counter = 0; out_stall_cnt = 0.
  - While rst_n is low, out_fetch_ready = 0 and out_dec_ena = 0.
  - Entry storage is not cleared.
  - Reset mid-operation discards all entries immediately, without waiting for a clock.
- States:
  - RUN: normal operation.
  - RECOVER: out_fetch_ready = 0, out_dec_ena = 0; hold counter decrements each cycle.
  - RECOVER -> RUN on the cycle the hold counter reaches 0. RECOVER therefore lasts exactly FLUSH_HOLD cycles.
- Classification:
  - is_mem = head opcode [6:0] is 0000011 (load) or 0100011 (store).
  - Every other opcode, including unknown ones, needs an RS slot.
- Dispatch condition (combinational):
  - out_dec_ena = RUN & count != 0 & !in_flush & !in_rob_full & (is_mem ? !in_lsq_full : !in_rs_full).
  - out_dec_inst/pc/pred_taken always show the head entry. They are don't-care when count = 0.
- Push/pop:
  - push = in_fetch_valid & out_fetch_ready, where out_fetch_ready = RUN & count != DEPTH & !in_flush.
  - pop = out_dec_ena.
  - On posedge: push writes at tail and advances tail; pop advances head. Pointers wrap modulo DEPTH.
  - count +1 on push only, -1 on pop only, unchanged on both.
  - Push while full is impossible because ready = 0.
  - Pop while empty is impossible because ena = 0.
  - No bypass: a pushed instruction reaches out_dec_ena no earlier than the next cycle, even when the buffer is empty.
  - Dispatch is strictly in order. A blocked head blocks all entries behind it.
- Flush:
  - in_flush on posedge: head = tail = count = 0; state = RECOVER; hold counter = FLUSH_HOLD - 1.
  - Flush takes priority over any push or pop in the same cycle; both are suppressed combinationally.
  - A flush arriving during RECOVER reloads the hold counter.
- Stall counter:
  - Increments on posedge when RUN & count != 0 & !in_flush & !out_dec_ena.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.

Test Plan:
- Reset then idle: out_count = 0, out_fetch_ready = 1, out_dec_ena = 0, out_stall_cnt = 0. Assert rst_n low mid-run with 5 entries -> out_count = 0 without waiting for a clock.
- Push ADDI 0x00100093 at pc 0x0 with all fulls low -> out_dec_ena = 1 exactly one cycle later, out_dec_pc = 0x0, out_count returns to 0 the cycle after.
- Push 8 instructions with in_rob_full = 1 -> out_count = 8, out_fetch_ready = 0, out_stall_cnt counts 1 per blocked cycle. Release in_rob_full -> 8 consecutive dispatches in push order; pointers wrap correctly on a following 8-entry refill.
- Head LW 0x00002083 with in_lsq_full = 1, in_rs_full = 0 -> blocked; the ADD queued behind it is also blocked. Drop in_lsq_full -> LW dispatches, then ADD. Repeat with head ADD and in_rs_full = 1 -> blocked.
- 4 entries queued, pulse in_flush together with in_fetch_valid = 1 -> no push, no dispatch, out_count = 0, out_fetch_ready = 0 for exactly FLUSH_HOLD = 2 cycles, then 1.
- Second in_flush pulse on the first cycle of RECOVER -> RECOVER extends to 2 cycles after the second pulse. Simultaneous push and pop with count = 3 -> count stays 3.
